// File: rtl/slow_decade_counter.sv
// ----------------------------------------------------------------------------
// slow_decade_counter
//
// Modulo-MODULO up counter (decade by default) that advances only on clock
// edges where slowena is high, so downstream logic can count at a reduced,
// externally gated rate while staying on the system clock. The terminal-count
// strobe tc is meant to drive the slowena of the next higher digit when
// several instances are cascaded (e.g. a multi-digit BCD timer).
//
// Parameters:
//   WIDTH   - bit width of q; 2**WIDTH must be >= MODULO
//   MODULO  - number of count states, q runs 0 .. MODULO-1 (2 .. 2**WIDTH)
//
// Ports:
//   clk      in   1      rising-edge clock, all state changes on this edge
//   reset    in   1      synchronous active-low reset (0 = clear q)
//   slowena  in   1      count enable, q advances once per enabled edge
//   q        out  WIDTH  registered count value
//   tc       out  1      combinational strobe: q == MODULO-1 and slowena
// ----------------------------------------------------------------------------
module slow_decade_counter #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MODULO = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slowena,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    // Reject parameter sets that cannot hold MODULO states in WIDTH bits.
    generate
        if (MODULO < 2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_param
            $error("slow_decade_counter: MODULO must lie in 2 .. 2**WIDTH");
        end
    endgenerate

    // Last legal count value, and MODULO widened by one bit so the
    // out-of-range compare also works when MODULO == 2**WIDTH.
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic             at_last;
    logic             out_of_range;
    logic [WIDTH-1:0] q_next;

    assign at_last      = (q == LAST);
    assign out_of_range = ({1'b0, q} >= MOD_EXT);

    // Wrap is decided by comparing against LAST, never by natural rollover,
    // so the increment can only be taken when q < LAST and cannot overflow.
    // A corrupted q (>= MODULO) is pulled back to zero whether enabled or not.
    always_comb begin
        q_next = q;
        if (out_of_range) begin
            q_next = '0;
        end else if (slowena) begin
            if (at_last) begin
                q_next = '0;
            end else begin
                q_next = q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    // High for exactly the cycle that precedes the wrap edge.
    assign tc = at_last && slowena;

endmodule

// File: tb/tb_slow_decade_counter.sv
// ----------------------------------------------------------------------------
// tb_slow_decade_counter
//
// Directed bench for slow_decade_counter. Two decade instances are cascaded:
// the units digit takes slowena from the bench, the tens digit takes the
// units tc as its enable. Single-digit tests look at the units digit; the
// cascade test looks at both. Inputs change 2 ns after a rising edge and
// outputs are sampled between edges.
// ----------------------------------------------------------------------------
module tb_slow_decade_counter;

    logic       clk;
    logic       reset;
    logic       slowena;
    logic [3:0] units_q;
    logic       units_tc;
    logic [3:0] tens_q;
    logic       tens_tc;

    int checks = 0;
    int errors = 0;

    int model;
    int tens_model;
    logic en;

    slow_decade_counter #(.WIDTH(4), .MODULO(10)) u_units (
        .clk     (clk),
        .reset   (reset),
        .slowena (slowena),
        .q       (units_q),
        .tc      (units_tc)
    );

    slow_decade_counter #(.WIDTH(4), .MODULO(10)) u_tens (
        .clk     (clk),
        .reset   (reset),
        .slowena (units_tc),
        .q       (tens_q),
        .tc      (tens_tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then let outputs settle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Synchronous reset of both digits with counting disabled afterwards.
    task automatic do_reset();
        reset   = 1'b0;
        slowena = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        slowena = 1'b0;

        // ---- Reset: two edges with slowena=0, then reset still 0 with slowena=1
        tick();
        tick();
        check("reset_q", 32'(units_q), 0);
        check("reset_tc", 32'(units_tc), 0);
        check("reset_tens_q", 32'(tens_q), 0);
        slowena = 1'b1;
        #1;
        check("reset_en_tc", 32'(units_tc), 0);
        tick();
        check("reset_priority_q", 32'(units_q), 0);
        tick();
        check("reset_priority_q2", 32'(units_q), 0);

        // ---- Gated hold
        reset   = 1'b1;
        slowena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_zero", 32'(units_q), 0);
        end
        slowena = 1'b1;
        tick();
        check("single_step", 32'(units_q), 1);
        slowena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_one", 32'(units_q), 1);
        end

        // ---- Full wrap: 12 enabled edges from 0 -> 1..9,0,1,2
        do_reset();
        check("wrap_start", 32'(units_q), 0);
        model   = 0;
        slowena = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            check("wrap_tc", 32'(units_tc), (model == 9) ? 1 : 0);
            tick();
            model = (model == 9) ? 0 : model + 1;
            check("wrap_q", 32'(units_q), 32'(model));
        end
        check("wrap_end", 32'(units_q), 2);

        // ---- Enable pattern 1,0,1,0... for 20 edges
        do_reset();
        model = 0;
        for (int i = 0; i < 20; i++) begin
            en      = (i % 2 == 0);
            slowena = en;
            #1;
            check("pattern_tc", 32'(units_tc), (model == 9 && en) ? 1 : 0);
            tick();
            if (en) model = (model == 9) ? 0 : model + 1;
            check("pattern_q", 32'(units_q), 32'(model));
        end
        check("pattern_end", 32'(units_q), 0);

        // ---- Reset mid-count: reach 7, then reset together with slowena=1
        do_reset();
        slowena = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("mid_reach7", 32'(units_q), 7);
        reset = 1'b0;
        tick();
        check("mid_reset_q", 32'(units_q), 0);
        check("mid_reset_tc", 32'(units_tc), 0);
        reset = 1'b1;
        tick();
        check("mid_resume1", 32'(units_q), 1);
        tick();
        check("mid_resume2", 32'(units_q), 2);

        // ---- Cascade: 100 enabled edges from reset
        do_reset();
        model      = 0;
        tens_model = 0;
        slowena    = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            #1;
            check("cascade_tens_tc", 32'(tens_tc),
                  (model == 9 && tens_model == 9) ? 1 : 0);
            tick();
            if (model == 9) tens_model = (tens_model == 9) ? 0 : tens_model + 1;
            model = (model == 9) ? 0 : model + 1;
            check("cascade_units", 32'(units_q), 32'(model));
            check("cascade_tens", 32'(tens_q), 32'(tens_model));
            if (i == 37) begin
                check("edge37_units", 32'(units_q), 7);
                check("edge37_tens", 32'(tens_q), 3);
            end
        end
        check("edge100_units", 32'(units_q), 0);
        check("edge100_tens", 32'(tens_q), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
